// File: rtl/instr_fetch_arbiter.sv
// instr_fetch_arbiter: shares the single-ported instr_buffer fetch port among
// NUM_REQ requesters. Round-robin grant, one fetch outstanding, and the
// response is routed back to the granted requester. Lost acks (timeout) and
// tag mismatches raise sticky error flags.
// Ports: clk, rst (async, active-low); req_valid/req_addr/req_tag in and
// req_ack out (requester side); fetch_rd_en/fetch_addr/fetch_tag out and
// fetchwave_ack/wave_instr/wave_tag in (buffer side); resp_valid/resp_id/
// resp_instr/resp_tag out (response); busy, err_timeout, err_tag_mismatch
// out; err_clr in (clears both sticky errors).
module instr_fetch_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*39-1:0] req_tag,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic                  fetch_rd_en,
    output logic [31:0]           fetch_addr,
    output logic [38:0]           fetch_tag,
    input  logic                  fetchwave_ack,
    input  logic [31:0]           wave_instr,
    input  logic [38:0]           wave_tag,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_instr,
    output logic [38:0]           resp_tag,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_tag_mismatch,
    input  logic                  err_clr
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]     r_id, w_id_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]  r_req_ack, w_req_ack_nxt;
    logic                r_rd_en, w_rd_en_nxt;
    logic [31:0]         r_addr, w_addr_nxt;
    logic [38:0]         r_tag, w_tag_nxt;
    logic                r_resp_valid, w_resp_valid_nxt;
    logic [ID_W-1:0]     r_resp_id, w_resp_id_nxt;
    logic [31:0]         r_resp_instr, w_resp_instr_nxt;
    logic [38:0]         r_resp_tag, w_resp_tag_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_err_to, w_err_to_nxt;
    logic                r_err_mm, w_err_mm_nxt;
    logic                w_set_to, w_set_mm;

    logic                w_win_vld;
    logic [ID_W-1:0]     w_win_id;
    logic [ID_W-1:0]     w_cand;

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = '0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_win_vld && req_valid[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_id  = w_cand;
            end
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_id_nxt         = r_id;
        w_cnt_nxt        = r_cnt;
        w_req_ack_nxt    = '0;
        w_rd_en_nxt      = 1'b0;
        w_addr_nxt       = r_addr;
        w_tag_nxt        = r_tag;
        w_resp_valid_nxt = 1'b0;
        w_resp_id_nxt    = r_resp_id;
        w_resp_instr_nxt = r_resp_instr;
        w_resp_tag_nxt   = r_resp_tag;
        w_set_to         = 1'b0;
        w_set_mm         = 1'b0;
        unique case (r_state)
            S_IDLE, S_RESP: begin
                if (w_win_vld) begin
                    w_state_nxt   = S_ISSUE;
                    w_ptr_nxt     = w_win_id;
                    w_id_nxt      = w_win_id;
                    w_addr_nxt    = req_addr[int'(w_win_id)*32 +: 32];
                    w_tag_nxt     = req_tag[int'(w_win_id)*39 +: 39];
                    w_req_ack_nxt = NUM_REQ'(1) << w_win_id;
                    w_rd_en_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                if (fetchwave_ack) begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_id_nxt    = r_id;
                    w_resp_instr_nxt = wave_instr;
                    w_resp_tag_nxt   = wave_tag;
                    w_set_mm         = (wave_tag != r_tag);
                end else if (r_cnt == CNT_LAST) begin
                    // Ack lost: abandon the fetch, no response.
                    w_state_nxt = S_IDLE;
                    w_set_to    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        // A new error in the same cycle as err_clr stays set.
        w_err_to_nxt = w_set_to | (r_err_to & ~err_clr);
        w_err_mm_nxt = w_set_mm | (r_err_mm & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= PTR_RST;
            r_id         <= '0;
            r_cnt        <= '0;
            r_req_ack    <= '0;
            r_rd_en      <= 1'b0;
            r_addr       <= '0;
            r_tag        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_instr <= '0;
            r_resp_tag   <= '0;
            r_busy       <= 1'b0;
            r_err_to     <= 1'b0;
            r_err_mm     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_id         <= w_id_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req_ack    <= w_req_ack_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_addr       <= w_addr_nxt;
            r_tag        <= w_tag_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_id    <= w_resp_id_nxt;
            r_resp_instr <= w_resp_instr_nxt;
            r_resp_tag   <= w_resp_tag_nxt;
            r_busy       <= w_busy_nxt;
            r_err_to     <= w_err_to_nxt;
            r_err_mm     <= w_err_mm_nxt;
        end
    end

    assign req_ack          = r_req_ack;
    assign fetch_rd_en      = r_rd_en;
    assign fetch_addr       = r_addr;
    assign fetch_tag        = r_tag;
    assign resp_valid       = r_resp_valid;
    assign resp_id          = r_resp_id;
    assign resp_instr       = r_resp_instr;
    assign resp_tag         = r_resp_tag;
    assign busy             = r_busy;
    assign err_timeout      = r_err_to;
    assign err_tag_mismatch = r_err_mm;

endmodule
